// File: rtl/sd_sched_pkg.sv
// Shared types and constants for the SD card read scheduler.
// Status codes mirror the sd_controller idleSD encoding.
package sd_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_XFER  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [3:0] SD_STATUS_READY   = 4'h0;
  localparam logic [3:0] SD_STATUS_BUSY_LO = 4'h8;
  localparam logic [3:0] SD_STATUS_BUSY_HI = 4'hB;

  localparam int DEF_WORDS_PER_BLOCK = 128;

  function automatic logic sd_is_busy(input logic [3:0] s);
    return (s >= SD_STATUS_BUSY_LO) && (s <= SD_STATUS_BUSY_HI);
  endfunction

endpackage

// File: rtl/sd_read_scheduler_rr.sv
// Two-way round-robin picker; on a tie the requester that was
// not the last owner wins. Last owner resets to B so A wins first.
module rr_arbiter2 (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_a_i,
  input  logic req_b_i,
  input  logic upd_i,
  input  logic upd_b_i,
  output logic pick_b_o
);

  logic last_b_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_b_q <= 1'b1;
    end else if (upd_i) begin
      last_b_q <= upd_b_i;
    end
  end

  assign pick_b_o = req_b_i & (~req_a_i | ~last_b_q);

endmodule

// File: rtl/sd_read_scheduler.sv
// Shares one SPI sd_controller between two requesters and
// sequences one complete single-block read per grant.
module sd_read_scheduler
  import sd_sched_pkg::*;
#(
  parameter int          WORDS_PER_BLOCK = DEF_WORDS_PER_BLOCK,
  parameter logic [23:0] TIMEOUT_CYCLES  = 24'd5_000_000
) (
  input  logic        iCLK,
  input  logic        Reset,
  input  logic        iReqA,
  input  logic        iReqB,
  input  logic [31:0] iAddrA,
  input  logic [31:0] iAddrB,
  output logic        oGrantA,
  output logic        oGrantB,
  output logic        oDoneA,
  output logic        oDoneB,
  output logic        oErr,
  output logic        oSDRead,
  output logic [31:0] oSDAddress,
  input  logic [3:0]  iSDStatus,
  input  logic        iWordReady,
  output logic        oBusy
);

  localparam logic [7:0] WPB = 8'(WORDS_PER_BLOCK);

  state_e      state_q;
  logic        own_b_q;
  logic        to_q;
  logic [7:0]  wcnt_q;
  logic [7:0]  wcnt_d;
  logic [23:0] cyc_q;
  logic [23:0] cyc_d;
  logic        tmo;
  logic        pick_b;

  logic        grant_a_q;
  logic        grant_b_q;
  logic        done_a_q;
  logic        done_b_q;
  logic        err_q;
  logic        sd_rd_q;
  logic        busy_q;
  logic [31:0] addr_q;

  rr_arbiter2 u_arb (
    .clk_i    (iCLK),
    .rst_i    (Reset),
    .req_a_i  (iReqA),
    .req_b_i  (iReqB),
    .upd_i    (state_q == S_DONE),
    .upd_b_i  (own_b_q),
    .pick_b_o (pick_b)
  );

  // Word count saturates so trailing pulses cannot wrap it.
  assign wcnt_d = (iWordReady && (wcnt_q < WPB)) ?
                  wcnt_q + 8'd1 : wcnt_q;
  assign cyc_d  = cyc_q + 24'd1;
  assign tmo    = (cyc_d >= TIMEOUT_CYCLES);

  always_ff @(posedge iCLK) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      own_b_q   <= 1'b0;
      to_q      <= 1'b0;
      wcnt_q    <= '0;
      cyc_q     <= '0;
      grant_a_q <= 1'b0;
      grant_b_q <= 1'b0;
      done_a_q  <= 1'b0;
      done_b_q  <= 1'b0;
      err_q     <= 1'b0;
      sd_rd_q   <= 1'b0;
      busy_q    <= 1'b0;
      addr_q    <= '0;
    end else begin
      done_a_q <= 1'b0;
      done_b_q <= 1'b0;
      err_q    <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          grant_a_q <= 1'b0;
          grant_b_q <= 1'b0;
          busy_q    <= 1'b0;
          sd_rd_q   <= 1'b0;
          if (iReqA || iReqB) begin
            own_b_q <= pick_b;
            addr_q  <= pick_b ? iAddrB : iAddrA;
            wcnt_q  <= '0;
            cyc_q   <= '0;
            to_q    <= 1'b0;
            state_q <= S_START;
          end
        end
        S_START: begin
          grant_a_q <= ~own_b_q;
          grant_b_q <= own_b_q;
          busy_q    <= 1'b1;
          wcnt_q    <= wcnt_d;
          cyc_q     <= cyc_d;
          if (tmo) begin
            sd_rd_q <= 1'b0;
            to_q    <= 1'b1;
            state_q <= S_DONE;
          end else if (sd_rd_q && sd_is_busy(iSDStatus)) begin
            sd_rd_q <= 1'b0;
            state_q <= S_XFER;
          end else begin
            sd_rd_q <= 1'b1;
          end
        end
        S_XFER: begin
          wcnt_q <= wcnt_d;
          cyc_q  <= cyc_d;
          if (wcnt_d == WPB && iSDStatus == SD_STATUS_READY) begin
            state_q <= S_DONE;
          end else if (tmo) begin
            to_q    <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          done_a_q <= ~own_b_q;
          done_b_q <= own_b_q;
          err_q    <= to_q;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign oGrantA    = grant_a_q;
  assign oGrantB    = grant_b_q;
  assign oDoneA     = done_a_q;
  assign oDoneB     = done_b_q;
  assign oErr       = err_q;
  assign oSDRead    = sd_rd_q;
  assign oSDAddress = addr_q;
  assign oBusy      = busy_q;

endmodule

// File: doc/sd_read_scheduler.md
# sd_read_scheduler

Two-requester scheduler for the SD card read path. It shares the single `sd_controller` (SPI, single-block read) between requester A and requester B; A is the CPU bus and B is the boot/DMA loader. It arbitrates requests round-robin and latches the winner's sector address. It then sequences one complete 128-word block read into the SD buffer and returns a per-requester done pulse, with a flag if the read timed out.

## Interface
Parameters:
- `WORDS_PER_BLOCK`, 128: `wordReady` pulses expected per block (one 512-byte sector).
- `TIMEOUT_CYCLES`, 24'd5_000_000: `iCLK` cycles allowed for one block read before it is aborted as an error.

Ports:
- `iCLK`  in  1  single clock for the whole block.
- `Reset`  in  1  reset, synchronous, active-high.
- `iReqA`, `iReqB`  in  1  level request; the requester holds it until its done pulse.
- `iAddrA`, `iAddrB`  in  32  sector address; sampled only at grant.
- `oGrantA`, `oGrantB`  out  1  owner indication; at most one is high.
- `oDoneA`, `oDoneB`  out  1  one-cycle completion pulse to the owner.
- `oErr`  out  1  high during a done pulse that ended by timeout.
- `oSDRead`  out  1  drives the controller `rd` input.
- `oSDAddress`  out  32  drives the controller `address` input.
- `iSDStatus`  in  4  controller `idleSD` status: 4'h0 means ready, 4'h8 to 4'hB mean a read is in progress.
- `iWordReady`  in  1  one-cycle pulse per word written to the buffer; already synchronised to `iCLK` upstream.
- `oBusy`  out  1  high whenever the state is not IDLE.

## Operation
- States: IDLE, START, XFER, DONE.
- IDLE:
  - With no request, stay in IDLE.
  - With a request, choose a winner (round-robin below), latch its address into `oSDAddress`, raise its grant and go to START.
- Round-robin rule:
  - If both requesters are high, the one that was *not* the last owner wins.
  - After reset the last owner is B, so A wins the first tie.
- START:
  - `oSDRead`=1.
  - Count `iWordReady` pulses from this state onward.
  - Go to XFER when `iSDStatus` is in 4'h8 to 4'hB.
- XFER:
  - `oSDRead`=0; keep counting words.
  - Go to DONE when word count == `WORDS_PER_BLOCK` and `iSDStatus`==4'h0.
- DONE:
  - Pulse `oDone` of the owner for one cycle; the grant stays high during this cycle.
  - Update the last-owner register, then go to IDLE.
- Timeout:
  - The cycle counter runs in START and XFER.
  - When it reaches `TIMEOUT_CYCLES`, go to DONE with `oErr`=1.
  - `oSDRead` drops immediately.
- Word counter:
  - 8 bits, saturating at `WORDS_PER_BLOCK`.
  - Pulses beyond the block size are ignored.
  - Pulses in IDLE or DONE are ignored.
  - The counter clears on entry to START.
- Requester drops its request mid-read: the transfer still completes (an SD read cannot be aborted) and the done pulse is still issued.
- Request changes during a read: new requests and address changes are ignored until IDLE.

## Timing
- Reset values: all grants, done pulses, `oErr`, `oSDRead` and `oBusy` are 0; `oSDAddress`=0; state IDLE; counters 0; last owner B.
- Reset mid-operation takes effect at the next edge:
  - Outputs return to their reset values.
  - An in-flight read gets no done pulse.
- Request seen in IDLE at edge t:
  - Grant, `oSDRead`=1, `oSDAddress` and `oBusy` are valid after edge t+1.
  - `oSDAddress` is held stable until the state returns to IDLE.
- `oSDRead` stays high for at least one cycle and until the busy status is seen.
- Done timing: if the last word and status 0 are both seen at edge d, the done pulse is high in the cycle after d+1 and the grant falls after d+2.
- Back-to-back requests: a pending request from the other requester is granted no earlier than two cycles after its done pulse (one IDLE cycle in between).
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package `sd_sched_pkg` holds:
  - the state encoding;
  - `SD_STATUS_READY`=4'h0;
  - `SD_STATUS_BUSY_LO`=4'h8 and `SD_STATUS_BUSY_HI`=4'hB;
  - the default block size.
- Sub-module `rr_arbiter2` is a two-way round-robin picker with a last-owner register. The FSM, the counters and the address latch live in the top module.

## Test plan
- After reset, hold `iReqA` with `iAddrA`=32'h0000_0800. The model goes busy 2 cycles after `oSDRead` rises and then sends 128 word pulses.
  - Expect: `oSDAddress`=32'h800, one `oDoneA` pulse, `oErr`=0, `oGrantB` never high.
- Raise `iReqA` and `iReqB` in the same cycle.
  - Expect: A is served first, then B after its done pulse plus one IDLE cycle.
  - Repeat the tie immediately: B now wins.
- The model never leaves status 4'h0.
  - Expect: `oSDRead` held high until `TIMEOUT_CYCLES` (set to 100 for this test), then `oDone` together with `oErr`=1, then IDLE.
- The model sends 130 word pulses.
  - Expect: done after the status returns to 0; extra pulses have no effect; the next transfer counts from 0.
- Assert `Reset` for one cycle at word 60 of a transfer.
  - Expect: all outputs at reset values on the next cycle and no done pulse; a new request completes normally.
